// File: rtl/lfsr_decoder_param_if.sv
// Bus between the LFSR decoder and its environment: byte memory read/write
// ports plus start request and run status.
interface lfsr_decoder_param_if #(
    parameter int AW = 8
);
    logic          start;
    logic [AW-1:0] raddr;
    logic [7:0]    rdata;
    logic          wr_en;
    logic [AW-1:0] waddr;
    logic [7:0]    wdata;
    logic          busy;
    logic          done;
    logic          err;
    logic [2:0]    pat_idx;
    logic [AW:0]   wr_count;

    modport master (
        output start, rdata,
        input  raddr, wr_en, waddr, wdata, busy, done, err, pat_idx, wr_count
    );

    modport slave (
        input  start, rdata,
        output raddr, wr_en, waddr, wdata, busy, done, err, pat_idx, wr_count
    );
endinterface

// File: rtl/lfsr_decoder_param.sv
// Stream decoder: recovers the LFSR tap set and seed from a known preamble,
// then XOR-decrypts the rest of the message and writes it with leading preamble stripped.
module lfsr_decoder_param #(
    parameter int                W         = 6,
    parameter int                NPAT      = 6,
    parameter logic [NPAT*W-1:0] TAPS      = {6'h39, 6'h36, 6'h33, 6'h30, 6'h2D, 6'h21},
    parameter int                AW        = 8,
    parameter int                RD_BASE   = 64,
    parameter int                WR_BASE   = 0,
    parameter int                MSG_LEN   = 64,
    parameter int                TRAIN_LEN = 7,
    parameter logic [7:0]        PRE_CHAR  = 8'h5F
) (
    input  logic                 clk,
    input  logic                 init,
    lfsr_decoder_param_if.slave  bus
);
    localparam int             AW1        = AW + 1;
    localparam logic [AW-1:0]  RD_BASE_A  = AW'(RD_BASE);
    localparam logic [AW-1:0]  WR_BASE_A  = AW'(WR_BASE);
    localparam logic [AW-1:0]  ONE_A      = AW'(1);
    localparam logic [AW:0]    ONE_C      = AW1'(1);
    localparam logic [AW:0]    TRAIN_LAST = AW1'(TRAIN_LEN - 1);
    localparam logic [AW:0]    MSG_LAST   = AW1'(MSG_LEN - 1);
    localparam logic [W-1:0]   PRE_W      = PRE_CHAR[W-1:0];

    typedef enum logic [2:0] {IDLE, SEED, TRAIN, DECODE, FIN} state_t;

    function automatic logic [W-1:0] lfsr_step(input logic [W-1:0] s, input logic [W-1:0] t);
        return {s[W-2:0], ^(s & t)};
    endfunction

    state_t          state_q;
    logic [AW:0]     k_q;
    logic [AW-1:0]   raddr_q;
    logic            strip_q;
    logic            busy_q;
    logic            done_q;
    logic            err_q;
    logic [2:0]      pat_q;
    logic [AW:0]     wr_cnt_q;
    logic [W-1:0]    lfsr_q [NPAT];
    logic [NPAT-1:0] mask_q;

    logic [W-1:0]    stepped [NPAT];
    logic [NPAT-1:0] mask_d;
    logic [W-1:0]    target;
    logic [2:0]      first_d;
    logic [W-1:0]    ks;
    logic [7:0]      pt;
    logic            wr_fire;

    always_comb begin
        target  = bus.rdata[W-1:0] ^ PRE_W;
        first_d = '0;
        ks      = '0;
        for (int p = 0; p < NPAT; p++) begin
            stepped[p] = lfsr_step(lfsr_q[p], TAPS[p*W +: W]);
            mask_d[p]  = mask_q[p] & (stepped[p] == target);
        end
        // Descending scan so the lowest surviving index wins.
        for (int p = NPAT - 1; p >= 0; p--) begin
            if (mask_d[p]) first_d = 3'(p);
        end
        for (int p = 0; p < NPAT; p++) begin
            if (pat_q == 3'(p)) ks = stepped[p];
        end
        pt      = bus.rdata ^ 8'(ks);
        wr_fire = (state_q == DECODE) && !init && !(strip_q && (pt == PRE_CHAR));
    end

    assign bus.raddr    = raddr_q;
    assign bus.wr_en    = wr_fire;
    assign bus.waddr    = WR_BASE_A + wr_cnt_q[AW-1:0];
    assign bus.wdata    = pt;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.pat_idx  = pat_q;
    assign bus.wr_count = wr_cnt_q;

    always_ff @(posedge clk) begin
        if (init) begin
            state_q  <= IDLE;
            k_q      <= '0;
            raddr_q  <= RD_BASE_A;
            strip_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            pat_q    <= '0;
            wr_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE, FIN: begin
                    if (bus.start) begin
                        state_q  <= SEED;
                        k_q      <= '0;
                        raddr_q  <= RD_BASE_A + ONE_A;
                        busy_q   <= 1'b1;
                        done_q   <= 1'b0;
                        err_q    <= 1'b0;
                        pat_q    <= '0;
                        wr_cnt_q <= '0;
                    end
                end
                SEED: begin
                    state_q <= TRAIN;
                    k_q     <= ONE_C;
                    raddr_q <= raddr_q + ONE_A;
                    strip_q <= 1'b1;
                end
                TRAIN: begin
                    k_q     <= k_q + ONE_C;
                    raddr_q <= raddr_q + ONE_A;
                    if (k_q == TRAIN_LAST) begin
                        if (mask_d == '0) begin
                            state_q <= FIN;
                            raddr_q <= RD_BASE_A;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end else begin
                            state_q <= DECODE;
                            pat_q   <= first_d;
                        end
                    end
                end
                DECODE: begin
                    k_q     <= k_q + ONE_C;
                    raddr_q <= raddr_q + ONE_A;
                    if (wr_fire) wr_cnt_q <= wr_cnt_q + ONE_C;
                    if (pt != PRE_CHAR) strip_q <= 1'b0;
                    if (k_q == MSG_LAST) begin
                        state_q <= FIN;
                        raddr_q <= RD_BASE_A;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Candidate LFSRs and survivor mask are pure datapath; they are always
    // reloaded in SEED before being used, so they carry no reset.
    always_ff @(posedge clk) begin
        if (state_q == SEED) begin
            for (int p = 0; p < NPAT; p++) lfsr_q[p] <= target;
            mask_q <= '1;
        end else if (state_q == TRAIN) begin
            lfsr_q <= stepped;
            mask_q <= mask_d;
        end else if (state_q == DECODE) begin
            lfsr_q <= stepped;
        end
    end
endmodule

// File: tb/tb_lfsr_decoder_param.sv
// Directed bench for lfsr_decoder_param: default instance plus a W=4 instance
// whose read window wraps past the top of the address space.
module tb_lfsr_decoder_param;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic init;
    int   errors = 0;
    int   checks = 0;

    lfsr_decoder_param_if #(.AW(8)) bus  ();
    lfsr_decoder_param_if #(.AW(8)) bus4 ();

    lfsr_decoder_param dut (
        .clk  (clk),
        .init (init),
        .bus  (bus)
    );

    lfsr_decoder_param #(
        .W       (4),
        .NPAT    (2),
        .TAPS    (8'hC9),
        .MSG_LEN (16),
        .RD_BASE (250)
    ) dut4 (
        .clk  (clk),
        .init (init),
        .bus  (bus4)
    );

    logic [7:0] mem   [256];
    logic [7:0] mem4  [256];
    logic [7:0] plain [256];
    logic [7:0] plain4[256];
    logic [7:0] ks_tab  [8] = '{8'h01, 8'h03, 8'h07, 8'h0E, 8'h1C, 8'h38, 8'h30, 8'h21};
    logic [7:0] ks4_tab [8] = '{8'h1, 8'h2, 8'h4, 8'h9, 8'h3, 8'h6, 8'hD, 8'hA};

    // Memory with one-cycle read latency, and a log of every write.
    int         n_wr  = 0;
    int         n_wr4 = 0;
    logic [7:0] wa_log  [1024];
    logic [7:0] wd_log  [1024];
    logic [7:0] wa4_log [1024];
    logic [7:0] wd4_log [1024];

    always @(posedge clk) begin
        bus.rdata  <= mem[bus.raddr];
        bus4.rdata <= mem4[bus4.raddr];
        if (bus.wr_en === 1'b1 && n_wr < 1024) begin
            wa_log[n_wr] <= bus.waddr;
            wd_log[n_wr] <= bus.wdata;
            n_wr         <= n_wr + 1;
        end
        if (bus4.wr_en === 1'b1 && n_wr4 < 1024) begin
            wa4_log[n_wr4] <= bus4.waddr;
            wd4_log[n_wr4] <= bus4.wdata;
            n_wr4          <= n_wr4 + 1;
        end
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int ks_step(input int w, input int taps, input int s);
        int fb;
        fb = $countones(s & taps) & 1;
        return ((s << 1) | fb) & ((1 << w) - 1);
    endfunction

    // Encrypt plain/plain4 into memory using the reference keystream.
    task automatic load(input bit four, input int w, input int taps, input int seed,
                        input int base, input int len);
        int s;
        s = seed;
        for (int k = 0; k < len; k++) begin
            if (k > 0) s = ks_step(w, taps, s);
            if (four) mem4[(base + k) % 256] = plain4[k] ^ 8'(s);
            else      mem[(base + k) % 256]  = plain[k] ^ 8'(s);
        end
    endtask

    task automatic fill_text(input int first_pre_end);
        for (int k = 0; k < 64; k++)
            plain[k] = (k < first_pre_end) ? 8'h5F : 8'(8'h41 + (k % 26));
    endtask

    task automatic load_main_hand();
        load(1'b0, 6, 'h2D, 1, 64, 64);
        for (int k = 0; k < 8; k++) mem[64 + k] = plain[k] ^ ks_tab[k];
    endtask

    task automatic run_main(output int lat);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        lat = 1;
        while (bus.done !== 1'b1 && lat < 200) begin
            tick();
            lat++;
        end
    endtask

    task automatic check_writes(input string tag, input bit four, input int base_n,
                                input int first_k, input int exp_n);
        int got;
        got = four ? (n_wr4 - base_n) : (n_wr - base_n);
        check({tag, " write count"}, got, exp_n);
        for (int i = 0; i < exp_n && i < got; i++) begin
            if (four) begin
                check({tag, " waddr"}, wa4_log[base_n + i], 8'(i));
                check({tag, " wdata"}, wd4_log[base_n + i], plain4[first_k + i]);
            end else begin
                check({tag, " waddr"}, wa_log[base_n + i], 8'(i));
                check({tag, " wdata"}, wd_log[base_n + i], plain[first_k + i]);
            end
        end
    endtask

    initial begin
        int lat;
        int base;
        for (int i = 0; i < 256; i++) begin
            mem[i]  = 8'h00;
            mem4[i] = 8'h00;
        end
        init       = 1'b1;
        bus.start  = 1'b0;
        bus4.start = 1'b0;
        tick();
        tick();

        check("reset done",     bus.done,     0);
        check("reset err",      bus.err,      0);
        check("reset busy",     bus.busy,     0);
        check("reset wr_en",    bus.wr_en,    0);
        check("reset pat_idx",  bus.pat_idx,  0);
        check("reset wr_count", bus.wr_count, 0);
        check("reset raddr",    bus.raddr,    64);
        check("reset raddr w4", bus4.raddr,   250);
        init = 1'b0;
        tick();

        // Basic decode: taps 0x2D (candidate 1), seed 1, 57 text bytes.
        fill_text(7);
        load_main_hand();
        base = n_wr;
        run_main(lat);
        check("basic latency",  lat,          65);
        check("basic pat_idx",  bus.pat_idx,  1);
        check("basic err",      bus.err,      0);
        check("basic busy",     bus.busy,     0);
        check("basic wr_count", bus.wr_count, 57);
        check("basic raddr",    bus.raddr,    64);
        check("basic first",    wd_log[base], 8'h48);
        check_writes("basic", 1'b0, base, 7, 57);

        // Ten leading preamble characters; a later one inside the text is kept.
        fill_text(10);
        plain[20] = 8'h5F;
        load_main_hand();
        base = n_wr;
        run_main(lat);
        check("strip latency",  lat,          65);
        check("strip wr_count", bus.wr_count, 54);
        check_writes("strip", 1'b0, base, 10, 54);

        // Corrupted preamble byte 3 eliminates every candidate.
        fill_text(7);
        load_main_hand();
        mem[64 + 3] = 8'h5F ^ 8'h2A;
        base = n_wr;
        run_main(lat);
        check("err latency",  lat,          8);
        check("err err",      bus.err,      1);
        check("err done",     bus.done,     1);
        check("err busy",     bus.busy,     0);
        check("err wr_count", bus.wr_count, 0);
        check("err writes",   n_wr - base,  0);

        // Message consisting only of preamble characters.
        fill_text(64);
        load_main_hand();
        base = n_wr;
        run_main(lat);
        check("allpre latency",  lat,          65);
        check("allpre err",      bus.err,      0);
        check("allpre wr_count", bus.wr_count, 0);
        check("allpre writes",   n_wr - base,  0);

        // W=4 instance, reads wrap 250..255, 0..9.
        for (int k = 0; k < 16; k++) plain4[k] = (k < 7) ? 8'h5F : 8'(8'h61 + k);
        load(1'b1, 4, 'hC, 1, 250, 16);
        for (int k = 0; k < 8; k++) mem4[(250 + k) % 256] = plain4[k] ^ ks4_tab[k];
        base = n_wr4;
        bus4.start = 1'b1;
        tick();
        bus4.start = 1'b0;
        lat = 1;
        while (bus4.done !== 1'b1 && lat < 200) begin
            tick();
            lat++;
        end
        check("w4 latency",  lat,           17);
        check("w4 pat_idx",  bus4.pat_idx,  1);
        check("w4 err",      bus4.err,      0);
        check("w4 wr_count", bus4.wr_count, 9);
        check("w4 raddr",    bus4.raddr,    250);
        check_writes("w4", 1'b1, base, 7, 9);

        // Abort with init during DECODE, then a clean run.
        fill_text(7);
        load_main_hand();
        base = n_wr;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (18) tick();
        check("abort busy before", bus.busy, 1);
        init = 1'b1;
        tick();
        check("abort done",     bus.done,     0);
        check("abort busy",     bus.busy,     0);
        check("abort err",      bus.err,      0);
        check("abort pat_idx",  bus.pat_idx,  0);
        check("abort wr_count", bus.wr_count, 0);
        check("abort raddr",    bus.raddr,    64);
        check_writes("abort", 1'b0, base, 7, 11);
        bus.start = 1'b1;
        tick();
        check("start under init", bus.busy, 0);
        init      = 1'b0;
        bus.start = 1'b0;
        repeat (5) tick();
        check("abort idle busy",   bus.busy,    0);
        check("abort no writes",   n_wr - base, 11);
        base = n_wr;
        run_main(lat);
        check("rerun latency",  lat,          65);
        check("rerun wr_count", bus.wr_count, 57);
        check_writes("rerun", 1'b0, base, 7, 57);

        // Start held three cycles and pulsed again mid-DECODE: one run only.
        base = n_wr;
        bus.start = 1'b1;
        tick();
        tick();
        tick();
        bus.start = 1'b0;
        lat = 3;
        while (lat < 30) begin
            tick();
            lat++;
        end
        bus.start = 1'b1;
        tick();
        lat++;
        bus.start = 1'b0;
        while (bus.done !== 1'b1 && lat < 200) begin
            tick();
            lat++;
        end
        check("hold latency",  lat,          65);
        check("hold pat_idx",  bus.pat_idx,  1);
        check("hold wr_count", bus.wr_count, 57);
        repeat (3) tick();
        check("hold done kept", bus.done, 1);
        check("hold busy",      bus.busy, 0);
        check_writes("hold", 1'b0, base, 7, 57);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
